// File: rtl/model_stream_loader.sv
// model_stream_loader: parses a little-endian byte stream of layer headers and weights into weight-memory writes.
// Define MODEL_LOADER_CHECKSUM_EN to verify a 32-bit byte-sum trailer after the last weight.
module model_stream_loader #(
  parameter int MAX_LAYERS = 10,
  parameter int MAX_DIM = 1024,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  input  logic [7:0]              s_data,
  output logic                    s_ready,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [WEIGHT_WIDTH-1:0] wr_data,
  output logic                    desc_valid,
  output logic [7:0]              desc_layer,
  output logic [31:0]             desc_rows,
  output logic [31:0]             desc_cols,
  output logic [ADDR_WIDTH-1:0]   desc_base,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              err_code
);
  localparam int WB = WEIGHT_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, NLAYERS, ROWS, COLS, WEIGHTS, CKSUM, DONE, ERR} state_t;
`ifdef MODEL_LOADER_CHECKSUM_EN
  localparam state_t FIN = CKSUM;
  logic [31:0] sum;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, state_nx;
  logic [2:0] err_nx;
  logic [23:0] sh;
  logic [31:0] val, nlay, rows_r, wleft;
  logic [1:0] bcnt;
  logic [ADDR_WIDTH:0] addr_cnt;
  logic [7:0] layer;
  logic idle, acc, last, ovf, lay_last, lay_bad, dim_bad;
  assign idle = state inside {IDLE, DONE, ERR};
  assign busy = !idle;
  assign s_ready = busy;
  assign done = state == DONE;
  assign error = state == ERR;
  assign acc = s_valid && s_ready;
  // val is the field assembled so far including the byte on the bus
  assign val = {s_data, sh};
  assign last = acc && bcnt == (state == WEIGHTS ? 2'(WB - 1) : 2'd3);
  // one extra counter bit flags an address past the top of memory
  assign ovf = addr_cnt[ADDR_WIDTH];
  assign lay_last = 32'(layer) + 32'd1 == nlay;
  assign lay_bad = val == 32'd0 || val > 32'(MAX_LAYERS);
  assign dim_bad = val == 32'd0 || val > 32'(MAX_DIM);
  always_comb begin
    state_nx = state;
    err_nx = err_code;
    case (state)
      NLAYERS: if (last) begin
        state_nx = lay_bad ? ERR : ROWS;
        err_nx = lay_bad ? 3'd1 : err_code;
      end
      ROWS: if (last) begin
        state_nx = dim_bad ? ERR : COLS;
        err_nx = dim_bad ? 3'd2 : err_code;
      end
      COLS: if (last) begin
        state_nx = dim_bad ? ERR : WEIGHTS;
        err_nx = dim_bad ? 3'd2 : err_code;
      end
      WEIGHTS: if (last) begin
        state_nx = ovf ? ERR : wleft != 32'd1 ? WEIGHTS : lay_last ? FIN : ROWS;
        err_nx = ovf ? 3'd3 : err_code;
      end
`ifdef MODEL_LOADER_CHECKSUM_EN
      CKSUM: if (last) begin
        state_nx = val == sum ? DONE : ERR;
        err_nx = val == sum ? 3'd0 : 3'd4;
      end
`endif
      default: if (start) begin
        state_nx = NLAYERS;
        err_nx = 3'd0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err_code <= '0;
    end else begin
      state <= state_nx;
      err_code <= err_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
      bcnt <= '0;
      nlay <= '0;
      rows_r <= '0;
      wleft <= '0;
      addr_cnt <= '0;
      layer <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      desc_valid <= 1'b0;
      desc_layer <= '0;
      desc_rows <= '0;
      desc_cols <= '0;
      desc_base <= '0;
`ifdef MODEL_LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      desc_valid <= 1'b0;
      if (acc) begin
        sh <= val[31:8];
        bcnt <= last ? 2'd0 : bcnt + 2'd1;
      end
      if (idle && start) begin
        bcnt <= '0;
        addr_cnt <= '0;
        layer <= '0;
`ifdef MODEL_LOADER_CHECKSUM_EN
        sum <= '0;
`endif
      end
      if (state == NLAYERS && last) nlay <= val;
      if (state == ROWS && last) rows_r <= val;
      if (state == COLS && last && !dim_bad) begin
        desc_valid <= 1'b1;
        desc_layer <= layer;
        desc_rows <= rows_r;
        desc_cols <= val;
        desc_base <= addr_cnt[ADDR_WIDTH-1:0];
        wleft <= rows_r * val;
      end
`ifdef MODEL_LOADER_CHECKSUM_EN
      if (state == WEIGHTS && acc) sum <= sum + 32'(s_data);
`endif
      if (state == WEIGHTS && last && !ovf) begin
        wr_en <= 1'b1;
        wr_addr <= addr_cnt[ADDR_WIDTH-1:0];
        wr_data <= val[31 -: WEIGHT_WIDTH];
        addr_cnt <= addr_cnt + 1'b1;
        wleft <= wleft - 32'd1;
        if (wleft == 32'd1) layer <= layer + 8'd1;
      end
    end
  end
endmodule
